// File: rtl/cam_capture_fb.sv
// Camera capture stage: frames OV7670 nibble data into RGB444 words and writes them to a frame buffer.
// Optional CAM_DECIMATE_EN keeps only even pixels of even lines (2:1 in each axis).
module cam_capture_fb #(
  parameter int unsigned PIX_NIBBLES = 4,
  parameter int unsigned LINE_PIX    = 320,
  parameter int unsigned FB_DEPTH    = 76800,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_arm,
  input  logic              i_continuous,
  input  logic [3:0]        i_d,
  input  logic              i_href,
  input  logic              i_vsync,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [11:0]       o_wr_data,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [7:0]        o_frame_cnt,
  output logic              o_ovf,
  output logic              o_line_err
);

  localparam int unsigned NibW = (PIX_NIBBLES > 1) ? $clog2(PIX_NIBBLES) : 1;
  // One spare bit so over-long lines saturate above LINE_PIX instead of aliasing.
  localparam int unsigned PixW = $clog2(LINE_PIX + 1) + 1;

  typedef enum logic [1:0] {StIdle, StWaitVs, StCapture, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        d_q;
  logic              href_q, href_qq, vs_q, vs_qq;
  logic              cont_q, cont_d;
  logic [NibW-1:0]   nib_q, nib_d;
  logic [PixW-1:0]   pix_q, pix_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       sr_q, sr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [11:0]       wr_data_q, wr_data_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic              ovf_q, ovf_d, lerr_q, lerr_d;
  logic              line_q, line_d;
  logic              vs_fall, vs_rise, active, keep;

  assign vs_fall = vs_qq & ~vs_q;
  assign vs_rise = ~vs_qq & vs_q;

  always_comb begin
    state_d   = state_q;
    cont_d    = cont_q;
    nib_d     = nib_q;
    pix_d     = pix_q;
    addr_d    = addr_q;
    sr_d      = sr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    fcnt_d    = fcnt_q;
    ovf_d     = ovf_q;
    lerr_d    = lerr_q;
    line_d    = line_q;
    keep      = 1'b1;
    active    = (state_q == StCapture) || ((state_q == StWaitVs) && vs_fall);

    if (i_arm) begin
      ovf_d  = 1'b0;
      lerr_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (i_arm) begin
          state_d = StWaitVs;
          cont_d  = i_continuous;
        end
      end
      StWaitVs: begin
        if (vs_fall) begin
          state_d = StCapture;
          nib_d   = '0;
          pix_d   = '0;
          addr_d  = '0;
          line_d  = 1'b0;
        end
      end
      StCapture: begin
        if (vs_rise) state_d = StDone;
      end
      StDone: begin
        fcnt_d  = fcnt_q + 8'd1;
        state_d = cont_q ? StWaitVs : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Counters below start from the values cleared above when the frame begins this cycle.
    if (active && href_q) begin
      sr_d = {sr_q[7:0], d_q};
      if (nib_d == NibW'(PIX_NIBBLES - 1)) begin
        nib_d = '0;
`ifdef CAM_DECIMATE_EN
        keep = ~pix_d[0] & ~line_d;
`endif
        if (keep) begin
          if (addr_d == ADDR_W'(FB_DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_d;
            wr_data_d = {sr_q[7:0], d_q};
            addr_d    = addr_d + 1'b1;
          end
        end
        if (pix_d != '1) pix_d = pix_d + 1'b1;
      end else begin
        nib_d = nib_d + 1'b1;
      end
    end else if ((state_q == StCapture) && href_qq && !href_q) begin
      nib_d = '0;
      if (pix_q != PixW'(LINE_PIX)) lerr_d = 1'b1;
      pix_d  = '0;
      line_d = ~line_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      d_q       <= '0;
      href_q    <= 1'b0;
      href_qq   <= 1'b0;
      vs_q      <= 1'b0;
      vs_qq     <= 1'b0;
      cont_q    <= 1'b0;
      nib_q     <= '0;
      pix_q     <= '0;
      addr_q    <= '0;
      sr_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      fcnt_q    <= '0;
      ovf_q     <= 1'b0;
      lerr_q    <= 1'b0;
      line_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_q       <= i_d;
      href_q    <= i_href;
      href_qq   <= href_q;
      vs_q      <= i_vsync;
      vs_qq     <= vs_q;
      cont_q    <= cont_d;
      nib_q     <= nib_d;
      pix_q     <= pix_d;
      addr_q    <= addr_d;
      sr_q      <= sr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      fcnt_q    <= fcnt_d;
      ovf_q     <= ovf_d;
      lerr_q    <= lerr_d;
      line_q    <= line_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_busy       = (state_q != StIdle);
  assign o_frame_done = (state_q == StDone);
  assign o_frame_cnt  = fcnt_q;
  assign o_ovf        = ovf_q;
  assign o_line_err   = lerr_q;

endmodule

// File: tb/tb_cam_capture_fb.sv
// Scoreboard bench for cam_capture_fb: a default instance plus a FB_DEPTH=8 instance for overflow.
module tb_cam_capture_fb;

  localparam int LinePix = 320;
  localparam int SmallDepth = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_arm, i_continuous, i_href, i_vsync;
  logic [3:0]  i_d;
  logic        o_wr_en, o_busy, o_frame_done, o_ovf, o_line_err;
  logic [16:0] o_wr_addr;
  logic [11:0] o_wr_data;
  logic [7:0]  o_frame_cnt;
  logic        s_wr_en, s_busy, s_frame_done, s_ovf, s_line_err;
  logic [16:0] s_wr_addr;
  logic [11:0] s_wr_data;
  logic [7:0]  s_frame_cnt;

  always #5 clk = ~clk;

  cam_capture_fb dut (
    .clk(clk), .rstn(rstn), .i_arm(i_arm), .i_continuous(i_continuous), .i_d(i_d),
    .i_href(i_href), .i_vsync(i_vsync), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_frame_cnt(o_frame_cnt), .o_ovf(o_ovf), .o_line_err(o_line_err)
  );

  cam_capture_fb #(.FB_DEPTH(SmallDepth)) dut_small (
    .clk(clk), .rstn(rstn), .i_arm(i_arm), .i_continuous(i_continuous), .i_d(i_d),
    .i_href(i_href), .i_vsync(i_vsync), .o_wr_en(s_wr_en), .o_wr_addr(s_wr_addr),
    .o_wr_data(s_wr_data), .o_busy(s_busy), .o_frame_done(s_frame_done),
    .o_frame_cnt(s_frame_cnt), .o_ovf(s_ovf), .o_line_err(s_line_err)
  );

  typedef struct packed {
    logic [16:0] addr;
    logic [11:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  bit  armed = 0, cont = 0, cap = 0, lerr_exp = 0;
  int  m_addr = 0, exp_frames = 0, done_seen = 0;
  int  s_writes = 0, s_base = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (o_frame_done === 1'b1) done_seen++;
      if (o_wr_en === 1'b1) begin
        if (exp_q.size() == 0) check_eq("unexpected_wr", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check_eq("wr_addr", 32'(o_wr_addr), 32'(e.addr));
          check_eq("wr_data", 32'(o_wr_data), 32'(e.data));
        end
      end
      if (s_wr_en === 1'b1) begin
        check_eq("small_addr", 32'(s_wr_addr), 32'(s_writes - s_base));
        s_writes++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wr_en"}, 32'(o_wr_en), 32'd0);
    check_eq({tag, "_wr_addr"}, 32'(o_wr_addr), 32'd0);
    check_eq({tag, "_wr_data"}, 32'(o_wr_data), 32'd0);
    check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
    check_eq({tag, "_done"}, 32'(o_frame_done), 32'd0);
    check_eq({tag, "_fcnt"}, 32'(o_frame_cnt), 32'd0);
    check_eq({tag, "_ovf"}, 32'(o_ovf), 32'd0);
    check_eq({tag, "_lerr"}, 32'(o_line_err), 32'd0);
    check_eq({tag, "_small_wr_en"}, 32'(s_wr_en), 32'd0);
  endtask

  task automatic arm(input bit c);
    i_arm = 1'b1;
    i_continuous = c;
    tick(1);
    i_arm = 1'b0;
    i_continuous = 1'b0;
    if (!armed && !cap) begin
      armed = 1'b1;
      cont = c;
    end
    lerr_exp = 1'b0;
    check_eq("arm_busy", 32'(o_busy), 32'(armed | cap));
    check_eq("arm_clr_lerr", 32'(o_line_err), 32'd0);
    check_eq("arm_clr_ovf", 32'(o_ovf), 32'd0);
    check_eq("arm_clr_small_ovf", 32'(s_ovf), 32'd0);
  endtask

  task automatic send_pixel(input logic [11:0] px, input bit even_line, input int idx);
    logic [15:0] nibs;
    bit keep;
    nibs = {4'h0, px};
    for (int k = 0; k < 4; k++) begin
      i_d = nibs[(3-k)*4 +: 4];
      i_href = 1'b1;
      tick(1);
    end
    if (cap) begin
      keep = 1'b1;
`ifdef CAM_DECIMATE_EN
      keep = even_line && (idx % 2 == 0);
`endif
      if (keep) begin
        exp_q.push_back('{addr: 17'(m_addr), data: px});
        m_addr++;
      end
    end
  endtask

  task automatic send_line(input int npix, input int extra, input bit rnd, input int line_idx);
    for (int p = 0; p < npix; p++)
      send_pixel(rnd ? 12'($urandom) : 12'hABC, (line_idx % 2) == 0, p);
    for (int x = 0; x < extra; x++) begin
      i_d = 4'($urandom);
      i_href = 1'b1;
      tick(1);
    end
    i_href = 1'b0;
    i_d = 4'h0;
    tick(4);
    if (cap && npix != LinePix) lerr_exp = 1'b1;
    check_eq("line_err", 32'(o_line_err), 32'(lerr_exp));
  endtask

  task automatic frame(input int nlines, input int npix, input int extra, input bit rnd,
                       input int arm_line);
    s_base = s_writes;
    if (armed) begin
      cap = 1'b1;
      armed = 1'b0;
      m_addr = 0;
    end
    i_vsync = 1'b0;
    tick(3);
    for (int l = 0; l < nlines; l++) begin
      if (l == arm_line) arm(1'b0);
      send_line(npix, extra, rnd, l);
    end
    i_vsync = 1'b1;
    tick(6);
    if (cap) begin
      cap = 1'b0;
      exp_frames++;
      armed = cont;
    end
    check_eq("frame_done_cnt", 32'(done_seen), 32'(exp_frames));
    check_eq("frame_cnt", 32'(o_frame_cnt), 32'(exp_frames % 256));
    check_eq("busy_after_frame", 32'(o_busy), 32'(armed));
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int sw;
    fork
      monitor();
    join_none
    rstn = 1'b0;
    i_arm = 1'b0;
    i_continuous = 1'b0;
    i_href = 1'b0;
    i_vsync = 1'b1;
    i_d = 4'h0;
    tick(3);
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick(4);

    // Single shot, 2 x 320 pixels of 12'hABC.
    arm(1'b0);
    frame(2, LinePix, 0, 1'b0, -1);

    // Arm mid-frame: that frame is skipped, the next is captured from address 0.
    frame(2, LinePix, 0, 1'b1, 1);
    frame(1, LinePix, 0, 1'b1, -1);

    // Short line with trailing partial pixel, then arm clears the sticky error.
    arm(1'b0);
    frame(1, LinePix - 1, 2, 1'b1, -1);
    arm(1'b0);

    // 10-pixel frame: overflows the 8-word instance only.
    sw = s_writes;
    frame(1, 10, 0, 1'b1, -1);
`ifdef CAM_DECIMATE_EN
    check_eq("small_writes", 32'(s_writes - sw), 32'd5);
    check_eq("small_ovf", 32'(s_ovf), 32'd0);
`else
    check_eq("small_writes", 32'(s_writes - sw), 32'(SmallDepth));
    check_eq("small_ovf", 32'(s_ovf), 32'd1);
`endif
    check_eq("main_ovf", 32'(o_ovf), 32'd0);

    // Continuous mode over three frames.
    arm(1'b1);
    for (int f = 0; f < 3; f++) frame(1, LinePix, 0, 1'b1, -1);

    // Reset in the middle of a captured frame.
    s_base = s_writes;
    cap = 1'b1;
    armed = 1'b0;
    m_addr = 0;
    i_vsync = 1'b0;
    tick(3);
    for (int p = 0; p < 5; p++) send_pixel(12'($urandom), 1'b1, 2 * p);
    i_d = 4'h0;
    tick(3);
    rstn = 1'b0;
    cap = 1'b0;
    cont = 1'b0;
    tick(1);
    check_reset_outputs("midreset");
    for (int p = 0; p < 3; p++) send_pixel(12'($urandom), 1'b1, 2 * p);
    rstn = 1'b1;
    for (int p = 0; p < 3; p++) send_pixel(12'($urandom), 1'b1, 2 * p);
    i_href = 1'b0;
    i_vsync = 1'b1;
    tick(6);
    check_eq("post_reset_busy", 32'(o_busy), 32'd0);
    check_eq("post_reset_fcnt", 32'(o_frame_cnt), 32'd0);
    check_eq("post_reset_done", 32'(done_seen), 32'(exp_frames));
    check_eq("post_reset_sb", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
